// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU opcode sequencer.
// The settle-counter width helper keeps a 1-bit counter even when SETTLE is 1.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  localparam int OPCODE_W = 3;
  localparam int NUM_OPS  = 8;

  function automatic int settle_cnt_w(input int settle);
    return ($clog2(settle) < 1) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Operand/opcode bus between the sequencer (master) and the ALU (slave).
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]                 A;
  logic [WIDTH-1:0]                 B;
  logic [alu_seq_pkg::OPCODE_W-1:0] Opcode;
  logic [WIDTH-1:0]                 Y;

  modport master (output A, output B, output Opcode, input Y);
  modport slave  (input A, input B, input Opcode, output Y);
endinterface

// File: rtl/alu_result_regfile.sv
// 8-entry result bank: one synchronous write port, one combinational read port,
// synchronous clear on rst.
module alu_result_regfile
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [OPCODE_W-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [OPCODE_W-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem [NUM_OPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sweeps all eight ALU opcodes over one latched operand pair, holding each for
// SETTLE cycles, capturing every Y into the result bank and a rotate-xor signature.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic [WIDTH-1:0]    A_in,
  input  logic [WIDTH-1:0]    B_in,
  alu_op_sequencer_if.master  alu,
  output logic                Busy,
  output logic                Done,
  input  logic [OPCODE_W-1:0] Rd_addr,
  output logic [WIDTH-1:0]    Rd_data,
  output logic [WIDTH-1:0]    Signature
);

  localparam int                  CNT_W    = settle_cnt_w(SETTLE);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [OPCODE_W-1:0] OP_LAST  = OPCODE_W'(NUM_OPS - 1);

  seq_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [OPCODE_W-1:0] opcode_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                capture;

  // Y is sampled on the last cycle of each opcode's settle window.
  assign capture = (state == DRIVE) && (cnt == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      Signature <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_q       <= A_in;
            b_q       <= B_in;
            opcode_q  <= '0;
            cnt       <= '0;
            Signature <= '0;
            Busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (capture) begin
            Signature <= {Signature[WIDTH-2:0], Signature[WIDTH-1]} ^ alu.Y;
            if (opcode_q == OP_LAST) begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              opcode_q <= opcode_q + 1'b1;
              cnt      <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign alu.A      = a_q;
  assign alu.B      = b_q;
  assign alu.Opcode = opcode_q;

  alu_result_regfile #(
    .WIDTH (WIDTH)
  ) u_results (
    .clk   (Clk),
    .rst   (Rst),
    .we    (capture),
    .waddr (opcode_q),
    .wdata (alu.Y),
    .raddr (Rd_addr),
    .rdata (Rd_data)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a SETTLE=2 and a SETTLE=1 instance, each fed by a
// behavioural ALU stub, checked against a per-sweep reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [2:0]  rd_addr = '0;
  int          stub_mode = 0;
  int          cur = 0;

  logic        busy0, done0, busy1, done1;
  logic [31:0] rd0, rd1, sig0, sig1;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer_if #(.WIDTH(32)) alu0 ();
  alu_op_sequencer_if #(.WIDTH(32)) alu1 ();

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input int mode, input logic [31:0] a,
                                         input logic [31:0] b, input logic [2:0] op);
    if (mode == 0) return a ^ {29'b0, op};
    if (mode == 1) return 32'h1;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return b >> 1;
    endcase
  endfunction

  assign alu0.Y = alu_fn(stub_mode, alu0.A, alu0.B, alu0.Opcode);
  assign alu1.Y = alu_fn(stub_mode, alu1.A, alu1.B, alu1.Opcode);

  alu_op_sequencer #(.WIDTH(32), .SETTLE(2)) u_dut (
    .Clk(clk), .Rst(rst), .Start(start0), .A_in(a_in), .B_in(b_in), .alu(alu0.master),
    .Busy(busy0), .Done(done0), .Rd_addr(rd_addr), .Rd_data(rd0), .Signature(sig0)
  );

  alu_op_sequencer #(.WIDTH(32), .SETTLE(1)) u_dut1 (
    .Clk(clk), .Rst(rst), .Start(start1), .A_in(a_in), .B_in(b_in), .alu(alu1.master),
    .Busy(busy1), .Done(done1), .Rd_addr(rd_addr), .Rd_data(rd1), .Signature(sig1)
  );

  wire        busy_m = (cur == 1) ? busy1 : busy0;
  wire        done_m = (cur == 1) ? done1 : done0;
  wire [31:0] rd_m   = (cur == 1) ? rd1 : rd0;
  wire [31:0] sig_m  = (cur == 1) ? sig1 : sig0;
  wire [31:0] a_m    = (cur == 1) ? alu1.A : alu0.A;
  wire [2:0]  op_m   = (cur == 1) ? alu1.Opcode : alu0.Opcode;

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v; else start0 = v;
  endtask

  // One sweep on DUT `sel`; optional second Start at cycle poke_at, optional reset
  // when Opcode first reaches abort_op.
  task automatic sweep(input int sel, input int mode, input logic [31:0] a, input logic [31:0] b,
                       input int poke_at, input int abort_op);
    int          s;
    int          ns;
    int          dones;
    bit          aborted;
    logic [31:0] exp_res [8];
    logic [31:0] exp_sig;
    s = (sel == 1) ? 1 : 2;
    ns = 8 * s;
    dones = 0;
    aborted = 0;
    cur = sel;
    stub_mode = mode;
    exp_sig = '0;
    for (int i = 0; i < 8; i++) begin
      exp_res[i] = alu_fn(mode, a, b, i[2:0]);
      exp_sig = {exp_sig[30:0], exp_sig[31]} ^ exp_res[i];
    end
    @(negedge clk);
    a_in = a; b_in = b;
    set_start(sel, 1'b1);
    @(posedge clk);
    for (int j = 0; j <= ns + 3 && !aborted; j++) begin
      @(negedge clk);
      if (j == poke_at) begin
        a_in = ~a; b_in = ~b;
        set_start(sel, 1'b1);
      end else begin
        set_start(sel, 1'b0);
      end
      if (done_m) dones++;
      n_checks++;
      if (j < ns) begin
        if (busy_m !== 1'b1 || done_m !== 1'b0 || op_m !== 3'(j / s)) begin
          n_fail++;
          $display("FAIL sweep_busy dut%0d cyc%0d: busy=%b done=%b op=%0d, want busy=1 done=0 op=%0d",
                   sel, j, busy_m, done_m, op_m, j / s);
        end
      end else if (j == ns) begin
        if (busy_m !== 1'b0 || done_m !== 1'b1 || op_m !== 3'd7) begin
          n_fail++;
          $display("FAIL sweep_done dut%0d cyc%0d: busy=%b done=%b op=%0d, want busy=0 done=1 op=7",
                   sel, j, busy_m, done_m, op_m);
        end
      end else begin
        if (busy_m !== 1'b0 || done_m !== 1'b0 || op_m !== 3'd7) begin
          n_fail++;
          $display("FAIL sweep_idle dut%0d cyc%0d: busy=%b done=%b op=%0d, want busy=0 done=0 op=7",
                   sel, j, busy_m, done_m, op_m);
        end
      end
      if (abort_op >= 0 && j < ns && (j % s) == 0 && (j / s) == abort_op) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy_m !== 1'b0 || done_m !== 1'b0 || op_m !== 3'd0 || a_m !== 32'h0 || sig_m !== 32'h0) begin
          n_fail++;
          $display("FAIL abort_state: busy=%b done=%b op=%0d A=%h sig=%h, want all zero",
                   busy_m, done_m, op_m, a_m, sig_m);
        end
        aborted = 1;
      end
    end
    if (aborted) begin
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (done_m) dones++;
      end
      n_checks++;
      if (dones != 0 || busy_m !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: dones=%0d busy=%b, want 0 0", dones, busy_m);
      end
      for (int i = 0; i < 8; i++) begin
        rd_addr = i[2:0];
        #1;
        n_checks++;
        if (rd_m !== 32'h0) begin
          n_fail++;
          $display("FAIL abort_result[%0d]: got %h want 0", i, rd_m);
        end
      end
    end else begin
      n_checks++;
      if (dones != 1 || a_m !== a) begin
        n_fail++;
        $display("FAIL sweep_once dut%0d: dones=%0d A=%h, want 1 %h", sel, dones, a_m, a);
      end
      for (int i = 0; i < 8; i++) begin
        rd_addr = i[2:0];
        #1;
        n_checks++;
        if (rd_m !== exp_res[i]) begin
          n_fail++;
          $display("FAIL result dut%0d[%0d]: got %h want %h", sel, i, rd_m, exp_res[i]);
        end
      end
      n_checks++;
      if (sig_m !== exp_sig) begin
        n_fail++;
        $display("FAIL signature dut%0d: got %h want %h", sel, sig_m, exp_sig);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start0 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || alu0.A !== 32'h0 || alu0.B !== 32'h0 ||
        alu0.Opcode !== 3'd0 || sig0 !== 32'h0 || busy1 !== 1'b0 || sig1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b A=%h B=%h op=%0d sig=%h, want all zero",
               busy0, done0, alu0.A, alu0.B, alu0.Opcode, sig0);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = i[2:0];
      #1;
      n_checks++;
      if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_result[%0d]: got %h/%h want 0", i, rd0, rd1);
      end
    end
  endtask

  task automatic test_full_sweep();
    logic [31:0] want [3];
    logic [2:0]  addr [3];
    want = '{32'h0FFAC078, 32'h0FFAC07B, 32'h0FFAC07F};
    addr = '{3'd0, 3'd3, 3'd7};
    sweep(0, 0, 32'h0FFAC078, 32'h0F42FAB2, -1, -1);
    for (int i = 0; i < 3; i++) begin
      rd_addr = addr[i];
      #1;
      n_checks++;
      if (rd0 !== want[i]) begin
        n_fail++;
        $display("FAIL full_sweep_const[%0d]: got %h want %h", addr[i], rd0, want[i]);
      end
    end
  endtask

  task automatic test_signature();
    sweep(0, 1, 32'h12345678, 32'h9ABCDEF0, -1, -1);
    n_checks++;
    if (sig0 !== 32'h000000FF) begin
      n_fail++;
      $display("FAIL signature_const: got %h want 000000ff", sig0);
    end
  endtask

  task automatic test_start_while_busy();
    sweep(0, 2, 32'hCAFE0001, 32'h00000123, 5, -1);
  endtask

  task automatic test_reset_mid_sweep();
    sweep(0, 2, 32'hDEADBEEF, 32'h01020304, -1, 4);
    sweep(0, 0, 32'h0FFAC078, 32'h0F42FAB2, -1, -1);
  endtask

  task automatic test_settle1();
    sweep(1, 0, 32'h0FFAC078, 32'h0F42FAB2, -1, -1);
    sweep(1, 2, 32'h80000001, 32'h7FFFFFFF, -1, -1);
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 6; n++) begin
      sweep(n % 2, 2, $urandom, $urandom, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_signature();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_settle1();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Synthesizable initiator for the `simpleALU` operand/opcode interface. On a single `Start` pulse it latches one operand pair and drives it into the ALU. It then steps `Opcode` through all eight operations, holding each for a programmable settle time, and captures every `Y` result into an internal result bank. It also folds the results into a running signature. The block sits in front of the ALU for self-test and bring-up, replacing bench-driven stimulus with on-chip sequencing.

## Interface
- `WIDTH`, 32, operand/result width
- `SETTLE`, 2, cycles each opcode is held before `Y` is sampled; must be ≥1 (0 is illegal)
- `NUM_OPS`, 8, number of opcodes swept (0..NUM_OPS-1); fixed at 8 for the 3-bit opcode
- `Clk`  in  1  clock, rising edge
- `Rst`  in  1  synchronous, active-high reset
- `Start`  in  1  request to begin a sweep; accepted only in IDLE
- `A_in`, `B_in`  in  WIDTH  operands, sampled on the edge that accepts `Start`
- `A`, `B`  out  WIDTH  operands driven to the ALU
- `Opcode`  out  3  opcode driven to the ALU
- `Y`  in  WIDTH  ALU result (combinational from `A`, `B`, `Opcode`)
- `Busy`  out  1  high while sweeping
- `Done`  out  1  one-cycle completion pulse
- `Rd_addr`  in  3  result-bank read index
- `Rd_data`  out  WIDTH  `result[Rd_addr]`, combinational read
- `Signature`  out  WIDTH  running fold of all captured results

## Operation
- States:
  - IDLE → DRIVE when `Start` is high. On that transition: latch `A_in`/`B_in` into `A`/`B`; set `Opcode`=0, settle count=0, `Signature`=0.
  - In DRIVE, the settle counter increments every cycle. When count==SETTLE-1:
    - write `result[Opcode]`=`Y`
    - `Signature` ← {Signature[WIDTH-2:0], Signature[WIDTH-1]} ^ `Y`
    - if `Opcode`==NUM_OPS-1, go to DONE; otherwise increment `Opcode` and clear the count
  - DONE → IDLE unconditionally after one cycle.
- `Busy`=1 exactly in DRIVE. `Done`=1 exactly in DONE. They are never high together.
- `Start` is ignored in DRIVE and DONE; there is no queuing.
- In IDLE, `A`, `B`, `Opcode`, `Signature` and the result bank hold their last values. Results stay readable until the next accepted `Start` overwrites them.
- Opcode wrap: `Opcode` never increments past NUM_OPS-1; it stays at 7 in DONE/IDLE.
- Reset (any state, including mid-sweep): state=IDLE; `A`=`B`=0; `Opcode`=0; `Busy`=`Done`=0; `Signature`=0; all result entries=0. An aborted sweep produces no `Done`.
- `Start` and `Rst` high on the same edge: reset wins.

## Timing
- The sweep is accepted on edge k, which samples `Start`. `Busy` rises after edge k.
- Each opcode is driven for SETTLE cycles. `Y` is sampled on the last edge of that window, so the ALU has SETTLE-1 full cycles plus one cycle of settling margin.
- `Done` is high in the cycle after edge k+NUM_OPS·SETTLE. With defaults this is 16 cycles after the accepting edge. `Busy` falls on that same edge.
- Earliest next accepted `Start` is the edge after `Done`, giving a minimum start-to-start spacing of NUM_OPS·SETTLE+2 cycles.
- `Rd_data` reflects a write on the cycle after the capturing edge.

## Structure
- Package `alu_seq_pkg` holds:
  - state enum (IDLE, DRIVE, DONE)
  - `OPCODE_W`=3, `NUM_OPS`=8
  - settle-counter width, derived from SETTLE via $clog2 with a minimum of 1
- Sub-module `alu_result_regfile` (8×WIDTH):
  - one synchronous write port (enable, 3-bit address, data)
  - one combinational read port
  - synchronous clear on `Rst`
- The top level contains the FSM, the settle and opcode counters, the operand registers and the signature register.

## Test plan
- Reset values: assert `Rst` 2 cycles. Then `A`=`B`=0, `Opcode`=0, `Busy`=`Done`=0, `Signature`=0, and `Rd_data`=0 for all `Rd_addr`.
- Full sweep:
  - Setup: bench ALU stub Y=A^{29'b0,Opcode}; `A_in`=32'h0FFAC078, `B_in`=32'h0F42FAB2; pulse `Start`.
  - Expect: `Opcode` steps 0..7, 2 cycles each. `Done` arrives 16 cycles after the accepting edge. `result[0]`=32'h0FFAC078, `result[3]`=32'h0FFAC07B, `result[7]`=32'h0FFAC07F.
- Signature fold: ALU stub Y=32'h1 constant, full sweep → `Signature`=32'h000000FF.
- Start while busy: pulse `Start` again at cycle 5 of a sweep with different `A_in`. Expect `A` unchanged, exactly one `Done`, and the original timing preserved.
- Reset mid-sweep: assert `Rst` when `Opcode`=4. Expect an immediate return to IDLE, `Busy`=0, no `Done`, all results 0. A following `Start` completes a normal sweep.
- SETTLE=1 build: full sweep. Expect `Done` 8 cycles after the accepting edge and a new `Opcode` every cycle, with results matching the stub.
